// File: rtl/uart_sender_if.sv
// Word handshake between a producer and the uart_sender serialiser.
interface uart_sender_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_sender.sv
// UART transmitter with a one-word holding register for back-to-back frames.
// Optional parity bit enabled by defining UART_SENDER_PARITY_EN.
module uart_sender #(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_sender_if.slave   tx,
  output logic           dout,
  output logic           tx_busy
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_SENDER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_nxt;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic [DATA_BITS-1:0] hold_reg, hold_nxt;
  logic [DATA_BITS-1:0] load_word;
  logic                 hold_full, hold_full_nxt;
  logic                 dout_nxt;
  logic                 accept, bit_end, stop_end, load_tx, load_hold;
`ifdef UART_SENDER_PARITY_EN
  logic                 parity_bit, parity_nxt;
`endif

  assign tx.tx_ready = ~hold_full;
  assign tx_busy     = (state != IDLE) | hold_full;
  assign accept      = tx.tx_valid & ~hold_full;
  assign bit_end     = (state != IDLE) && (baud_cnt == BAUD_W'(CLK_DIV - 1));
  assign stop_end    = (state == STOP) && bit_end && (bit_cnt == BIT_W'(STOP_BITS - 1));

  // A word arriving exactly as the last stop bit ends goes straight into the
  // shift register so the line never idles and the word is never stranded.
  assign load_hold = stop_end & hold_full;
  assign load_tx   = accept & ((state == IDLE) | (stop_end & ~hold_full));
  assign load_word = load_hold ? hold_reg : tx.tx_data;

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift_reg;
    hold_nxt      = hold_reg;
    hold_full_nxt = hold_full & ~load_hold;
`ifdef UART_SENDER_PARITY_EN
    parity_nxt    = parity_bit;
`endif
    case (state)
      IDLE:  if (load_tx) state_nxt = START;
      START: if (bit_end) state_nxt = DATA;
      DATA: begin
        if (bit_end) begin
          shift_nxt = {1'b1, shift_reg[DATA_BITS-1:1]};
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_nxt = '0;
`ifdef UART_SENDER_PARITY_EN
            state_nxt   = PARITY;
`else
            state_nxt   = STOP;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_SENDER_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          if (stop_end) begin
            bit_cnt_nxt = '0;
            state_nxt   = (load_hold | load_tx) ? START : IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load_hold | load_tx) begin
      shift_nxt  = load_word;
`ifdef UART_SENDER_PARITY_EN
      parity_nxt = (^load_word) ^ (PARITY_ODD != 0);
`endif
    end
    if (accept & ~load_tx) begin
      hold_nxt      = tx.tx_data;
      hold_full_nxt = 1'b1;
    end

    // Line level follows the next state so dout is registered yet aligned.
    case (state_nxt)
      START:   dout_nxt = 1'b0;
      DATA:    dout_nxt = shift_nxt[0];
`ifdef UART_SENDER_PARITY_EN
      PARITY:  dout_nxt = parity_nxt;
`endif
      default: dout_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      shift_reg <= '1;
      dout      <= 1'b1;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      bit_cnt   <= bit_cnt_nxt;
      hold_full <= hold_full_nxt;
      shift_reg <= shift_nxt;
      dout      <= dout_nxt;
    end
  end

  always_ff @(posedge clk) begin
    hold_reg   <= hold_nxt;
`ifdef UART_SENDER_PARITY_EN
    parity_bit <= parity_nxt;
`endif
  end

endmodule
